// File: rtl/riscv_dmem_arbiter.sv
// Data-memory arbiter: CPU-priority access to a single-port memory with a
// DMA anti-starvation counter and single outstanding-read return routing.
module riscv_dmem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_wen,
    input  logic [XLEN-1:0]   i_cpu_addr,
    input  logic [XLEN-1:0]   i_cpu_wr_data,
    input  logic [XLEN/8-1:0] i_cpu_byte_sel,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    output logic [XLEN-1:0]   o_cpu_rd_data,
    input  logic              i_dma_req,
    input  logic              i_dma_wen,
    input  logic [XLEN-1:0]   i_dma_addr,
    input  logic [XLEN-1:0]   i_dma_wr_data,
    input  logic [XLEN/8-1:0] i_dma_byte_sel,
    output logic              o_dma_gnt,
    output logic              o_dma_rvalid,
    output logic [XLEN-1:0]   o_dma_rd_data,
    output logic              o_mem_en,
    output logic              o_mem_wen,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wr_data,
    output logic [XLEN/8-1:0] o_mem_byte_sel,
    input  logic [XLEN-1:0]   i_mem_rd_data,
    input  logic              i_mem_ready
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic             OWN_CPU = 1'b0;
    localparam logic             OWN_DMA = 1'b1;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_owner_q, rd_owner_d;
    logic             cpu_gnt, dma_gnt;

    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!i_rst && i_mem_ready) begin
            if (i_cpu_req && i_dma_req) begin
                if (wait_cnt_q == LIMIT) dma_gnt = 1'b1;
                else                     cpu_gnt = 1'b1;
            end else if (i_cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (i_dma_req) begin
                dma_gnt = 1'b1;
            end
        end
    end

    assign o_cpu_gnt = cpu_gnt;
    assign o_dma_gnt = dma_gnt;

    always_comb begin
        o_mem_en       = cpu_gnt | dma_gnt;
        o_mem_wen      = 1'b0;
        o_mem_addr     = i_cpu_addr;
        o_mem_wr_data  = i_cpu_wr_data;
        o_mem_byte_sel = '0;
        if (dma_gnt) begin
            o_mem_wen      = i_dma_wen;
            o_mem_addr     = i_dma_addr;
            o_mem_wr_data  = i_dma_wr_data;
            o_mem_byte_sel = i_dma_byte_sel;
        end else if (cpu_gnt) begin
            o_mem_wen      = i_cpu_wen;
            o_mem_byte_sel = i_cpu_byte_sel;
        end
    end

    // Counts stalled DMA cycles, including those lost to memory back-pressure.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (i_rst || !i_dma_req || dma_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != LIMIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_comb begin
        rd_pend_d  = 1'b0;
        rd_owner_d = rd_owner_q;
        if (i_rst) begin
            rd_owner_d = OWN_CPU;
        end else if (o_mem_en && !o_mem_wen) begin
            rd_pend_d  = 1'b1;
            rd_owner_d = dma_gnt ? OWN_DMA : OWN_CPU;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_CPU;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Reset in the cycle after a load grant drops the return immediately.
    assign o_cpu_rvalid  = rd_pend_q && !i_rst && (rd_owner_q == OWN_CPU);
    assign o_dma_rvalid  = rd_pend_q && !i_rst && (rd_owner_q == OWN_DMA);
    assign o_cpu_rd_data = o_cpu_rvalid ? i_mem_rd_data : '0;
    assign o_dma_rd_data = o_dma_rvalid ? i_mem_rd_data : '0;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Bench for riscv_dmem_arbiter: cycle-level reference model plus
// directed scenarios with literal expectations.
module tb_riscv_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cpu_req, i_cpu_wen;
    logic [31:0] i_cpu_addr, i_cpu_wr_data;
    logic [3:0]  i_cpu_byte_sel;
    logic        o_cpu_gnt, o_cpu_rvalid;
    logic [31:0] o_cpu_rd_data;
    logic        i_dma_req, i_dma_wen;
    logic [31:0] i_dma_addr, i_dma_wr_data;
    logic [3:0]  i_dma_byte_sel;
    logic        o_dma_gnt, o_dma_rvalid;
    logic [31:0] o_dma_rd_data;
    logic        o_mem_en, o_mem_wen;
    logic [31:0] o_mem_addr, o_mem_wr_data;
    logic [3:0]  o_mem_byte_sel;
    logic [31:0] i_mem_rd_data = 32'h0;
    logic        i_mem_ready;

    int n_chk  = 0;
    int n_fail = 0;

    riscv_dmem_arbiter #(.XLEN(32), .STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cpu_req(i_cpu_req), .i_cpu_wen(i_cpu_wen),
        .i_cpu_addr(i_cpu_addr), .i_cpu_wr_data(i_cpu_wr_data),
        .i_cpu_byte_sel(i_cpu_byte_sel), .o_cpu_gnt(o_cpu_gnt),
        .o_cpu_rvalid(o_cpu_rvalid), .o_cpu_rd_data(o_cpu_rd_data),
        .i_dma_req(i_dma_req), .i_dma_wen(i_dma_wen),
        .i_dma_addr(i_dma_addr), .i_dma_wr_data(i_dma_wr_data),
        .i_dma_byte_sel(i_dma_byte_sel), .o_dma_gnt(o_dma_gnt),
        .o_dma_rvalid(o_dma_rvalid), .o_dma_rd_data(o_dma_rd_data),
        .o_mem_en(o_mem_en), .o_mem_wen(o_mem_wen),
        .o_mem_addr(o_mem_addr), .o_mem_wr_data(o_mem_wr_data),
        .o_mem_byte_sel(o_mem_byte_sel), .i_mem_rd_data(i_mem_rd_data),
        .i_mem_ready(i_mem_ready)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory: read data one cycle after a read strobe, garbage otherwise.
    always @(posedge i_clk) begin
        if (o_mem_en && !o_mem_wen) i_mem_rd_data <= word_at(o_mem_addr);
        else                        i_mem_rd_data <= $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: denied-cycle count and the single pending read.
    int          m_denied = 0;
    int          m_pend   = -1;
    logic [31:0] m_paddr  = 32'h0;

    always @(negedge i_clk) begin
        bit eg_c, eg_d, any, ewen;
        logic [31:0] eaddr, edata;
        logic [3:0]  ebs;
        bit ev_c, ev_d;
        eg_c = 0;
        eg_d = 0;
        if (!i_rst && i_mem_ready) begin
            if (i_cpu_req && i_dma_req) begin
                if (m_denied >= LIMIT) eg_d = 1;
                else                   eg_c = 1;
            end else begin
                eg_c = i_cpu_req;
                eg_d = i_dma_req;
            end
        end
        any   = eg_c | eg_d;
        ewen  = eg_d ? i_dma_wen : (eg_c ? i_cpu_wen : 1'b0);
        eaddr = eg_d ? i_dma_addr : i_cpu_addr;
        edata = eg_d ? i_dma_wr_data : i_cpu_wr_data;
        ebs   = eg_d ? i_dma_byte_sel : (eg_c ? i_cpu_byte_sel : 4'h0);
        ev_c  = !i_rst && (m_pend == 0);
        ev_d  = !i_rst && (m_pend == 1);
        chk("cpu_gnt", 32'(o_cpu_gnt), 32'(eg_c));
        chk("dma_gnt", 32'(o_dma_gnt), 32'(eg_d));
        chk("mem_en", 32'(o_mem_en), 32'(any));
        chk("mem_wen", 32'(o_mem_wen), 32'(ewen));
        chk("mem_bs", 32'(o_mem_byte_sel), 32'(ebs));
        if (any) begin
            chk("mem_addr", o_mem_addr, eaddr);
            chk("mem_wdata", o_mem_wr_data, edata);
        end
        chk("cpu_rvalid", 32'(o_cpu_rvalid), 32'(ev_c));
        chk("dma_rvalid", 32'(o_dma_rvalid), 32'(ev_d));
        chk("cpu_rdata", o_cpu_rd_data, ev_c ? word_at(m_paddr) : 32'h0);
        chk("dma_rdata", o_dma_rd_data, ev_d ? word_at(m_paddr) : 32'h0);
        if (i_rst || !i_dma_req || eg_d) m_denied = 0;
        else if (m_denied < LIMIT)       m_denied++;
        if (any && !ewen) begin
            m_pend  = eg_d ? 1 : 0;
            m_paddr = eaddr;
        end else begin
            m_pend = -1;
        end
    end

    task automatic nxt();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cpu(input logic r, input logic w, input logic [31:0] a);
        i_cpu_req      = r;
        i_cpu_wen      = w;
        i_cpu_addr     = a;
        i_cpu_wr_data  = a ^ 32'h5A5A_0000;
        i_cpu_byte_sel = 4'hF;
    endtask

    task automatic dma(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] bs);
        i_dma_req      = r;
        i_dma_wen      = w;
        i_dma_addr     = a;
        i_dma_wr_data  = d;
        i_dma_byte_sel = bs;
    endtask

    initial begin
        logic [9:0] pat;
        i_rst       = 1'b1;
        i_mem_ready = 1'b1;
        cpu(1, 0, 32'h10);
        dma(1, 0, 32'h20, 32'h0, 4'hF);
        @(negedge i_clk);
        chk("rst_cpu_gnt", 32'(o_cpu_gnt), 32'd0);
        chk("rst_dma_gnt", 32'(o_dma_gnt), 32'd0);
        chk("rst_mem_en", 32'(o_mem_en), 32'd0);
        nxt();
        @(negedge i_clk);
        chk("rst_cpu_rvalid", 32'(o_cpu_rvalid), 32'd0);
        nxt();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_cpu_gnt", 32'(o_cpu_gnt), 32'd1);
        nxt();
        cpu(0, 0, 32'h0);
        dma(0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge i_clk);

        nxt();
        cpu(1, 0, 32'h100);
        @(negedge i_clk);
        chk("ld_cpu_gnt", 32'(o_cpu_gnt), 32'd1);
        nxt();
        cpu(0, 0, 32'h0);
        @(negedge i_clk);
        chk("ld_cpu_rvalid", 32'(o_cpu_rvalid), 32'd1);
        chk("ld_cpu_rdata", o_cpu_rd_data, 32'hDEADBEEF);
        chk("ld_dma_rvalid", 32'(o_dma_rvalid), 32'd0);

        nxt();
        cpu(1, 0, 32'h200);
        dma(1, 0, 32'h300, 32'h0, 4'hF);
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            pat[i] = o_dma_gnt;
            nxt();
        end
        chk("starve_pattern", 32'(pat), 32'(10'b10000_10000));
        cpu(0, 0, 32'h0);
        dma(0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge i_clk);

        nxt();
        dma(1, 1, 32'h400, 32'h12345678, 4'b0011);
        i_mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("nrdy_mem_en", 32'(o_mem_en), 32'd0);
            nxt();
        end
        i_mem_ready = 1'b1;
        @(negedge i_clk);
        chk("st_mem_en", 32'(o_mem_en), 32'd1);
        chk("st_mem_wen", 32'(o_mem_wen), 32'd1);
        chk("st_mem_bs", 32'(o_mem_byte_sel), 32'h3);
        chk("st_mem_wdata", o_mem_wr_data, 32'h12345678);
        nxt();
        dma(0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge i_clk);
        chk("st_no_rvalid", 32'(o_dma_rvalid), 32'd0);

        for (int i = 0; i < 6; i++) begin
            nxt();
            if (i % 2 == 0) begin
                cpu(1, 0, 32'h500 + 32'(4 * i));
                dma(0, 0, 32'h0, 32'h0, 4'h0);
            end else begin
                cpu(0, 0, 32'h0);
                dma(1, 0, 32'h500 + 32'(4 * i), 32'h0, 4'hF);
            end
            @(negedge i_clk);
            chk("alt_gnt", 32'(i % 2 == 0 ? o_cpu_gnt : o_dma_gnt), 32'd1);
            if (i > 0) begin
                chk("alt_cpu_rv", 32'(o_cpu_rvalid), 32'(i % 2 == 1));
                chk("alt_dma_rv", 32'(o_dma_rvalid), 32'(i % 2 == 0));
            end
        end
        nxt();
        cpu(0, 0, 32'h0);
        dma(0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge i_clk);
        chk("alt_last_dma_rv", 32'(o_dma_rvalid), 32'd1);
        chk("alt_last_rdata", o_dma_rd_data, word_at(32'h514));

        nxt();
        dma(1, 0, 32'h600, 32'h0, 4'hF);
        @(negedge i_clk);
        chk("rr_dma_gnt", 32'(o_dma_gnt), 32'd1);
        nxt();
        dma(0, 0, 32'h0, 32'h0, 4'h0);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rr_dma_rvalid", 32'(o_dma_rvalid), 32'd0);
        nxt();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rr_no_late_rv", 32'(o_dma_rvalid), 32'd0);
        nxt();
        cpu(1, 0, 32'h700);
        @(negedge i_clk);
        chk("rr_cpu_gnt", 32'(o_cpu_gnt), 32'd1);
        nxt();
        cpu(0, 0, 32'h0);
        @(negedge i_clk);
        chk("rr_cpu_rvalid", 32'(o_cpu_rvalid), 32'd1);
        nxt();
        nxt();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
